// File: rtl/dataproc_dma_pkg.sv
// Shared register map, control/status bit positions, FSM encoding and bus request type
// for the data-processing DMA sequencer.
package dataproc_dma_pkg;

  localparam logic [3:0] REG_SRC  = 4'h0;
  localparam logic [3:0] REG_DST  = 4'h4;
  localparam logic [3:0] REG_LEN  = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hC;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_IE    = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_IE   = 3;

  localparam int DMA_WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_MEM,
    ST_WR_ACC,
    ST_RD_ACC,
    ST_WR_MEM,
    ST_NEXT,
    ST_DONE
  } dma_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wdat[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dataproc_bus_master.sv
// Single-transaction native-bus master: valid rises the cycle after req, request held stable
// until ready; valid is withdrawn only on ready or after TIMEOUT_CYCLES unanswered cycles.
module dataproc_bus_master
  import dataproc_dma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  bus_req_t    req_dat,
  output logic        valid,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        ready,
  output logic        done,
  output logic        tmo
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  assign done = valid && ready;
  assign tmo  = valid && !ready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid    <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      wstrb    <= '0;
      wait_cnt <= '0;
    end else if (valid) begin
      if (ready || tmo) valid <= 1'b0;
      else              wait_cnt <= wait_cnt + CW'(1);
    end else if (req) begin
      // Request is latched at launch so the bus sees it stable for the whole handshake.
      valid    <= 1'b1;
      addr     <= req_dat.addr;
      wdata    <= req_dat.wdata;
      wstrb    <= req_dat.wstrb;
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/dataproc_dma_ctrl.sv
// Register-programmed sequencer: per word reads memory, pushes it through the accelerator,
// writes the result back; 9 cycles/word with zero-wait slaves, stalls on either master's ready.
module dataproc_dma_ctrl
  import dataproc_dma_pkg::*;
#(
  parameter logic [31:0] ACC_DIN_OFF    = 32'h0000_0000,
  parameter logic [31:0] ACC_DOUT_OFF   = 32'h0000_0004,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          LEN_W          = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [3:0]  s_addr,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic [31:0] s_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [31:0] a_addr,
  output logic [31:0] a_wdata,
  output logic [3:0]  a_wstrb,
  input  logic [31:0] a_rdata,
  output logic        irq
);

  dma_state_t       state, state_nxt;
  logic [31:0]      src_q, dst_q, wsrc_q, wdst_q, data_q;
  logic [LEN_W-1:0] len_q, wcnt_q;
  logic             done_q, err_q, ie_q, abort_q;
  logic             reg_acc, reg_wr, ctrl_wr, start_req, dma_busy;
  logic             mem_req, acc_req, mem_done, acc_done, mem_tmo, acc_tmo;
  bus_req_t         mem_req_dat, acc_req_dat;
  logic [31:0]      status, rd_mux;

  assign reg_acc   = s_valid && !s_ready;
  assign reg_wr    = reg_acc && (s_wstrb != 4'h0);
  assign ctrl_wr   = reg_wr && (s_addr == REG_CTRL) && s_wstrb[0];
  assign dma_busy  = (state != ST_IDLE);
  assign start_req = ctrl_wr && !dma_busy && s_wdata[CTRL_START];
  assign irq       = done_q & ie_q;

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = dma_busy && (state != ST_DONE);
    status[STAT_DONE] = done_q;
    status[STAT_ERR]  = err_q;
    status[STAT_IE]   = ie_q;
    status[31:16]     = 16'(wcnt_q);
    case (s_addr)
      REG_SRC:  rd_mux = src_q;
      REG_DST:  rd_mux = dst_q;
      REG_LEN:  rd_mux = 32'(len_q);
      REG_CTRL: rd_mux = status;
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    acc_req     = 1'b0;
    mem_req_dat = '0;
    acc_req_dat = '0;
    case (state)
      ST_IDLE: if (start_req && (len_q != '0)) state_nxt = ST_RD_MEM;
      ST_RD_MEM: begin
        mem_req     = 1'b1;
        mem_req_dat = '{addr: wsrc_q, wdata: 32'h0, wstrb: 4'h0};
        if (mem_tmo)       state_nxt = ST_IDLE;
        else if (mem_done) state_nxt = ST_WR_ACC;
      end
      ST_WR_ACC: begin
        acc_req     = 1'b1;
        acc_req_dat = '{addr: ACC_DIN_OFF, wdata: data_q, wstrb: 4'hF};
        if (acc_tmo)       state_nxt = ST_IDLE;
        else if (acc_done) state_nxt = ST_RD_ACC;
      end
      ST_RD_ACC: begin
        acc_req     = 1'b1;
        acc_req_dat = '{addr: ACC_DOUT_OFF, wdata: 32'h0, wstrb: 4'h0};
        if (acc_tmo)       state_nxt = ST_IDLE;
        else if (acc_done) state_nxt = ST_WR_MEM;
      end
      ST_WR_MEM: begin
        mem_req     = 1'b1;
        mem_req_dat = '{addr: wdst_q, wdata: data_q, wstrb: 4'hF};
        if (mem_tmo)       state_nxt = ST_IDLE;
        else if (mem_done) state_nxt = ST_NEXT;
      end
      // Abort wins over completion so an aborted last word never reports done.
      ST_NEXT: begin
        if (abort_q)                     state_nxt = ST_IDLE;
        else if (wcnt_q == LEN_W'(1))    state_nxt = ST_DONE;
        else                             state_nxt = ST_RD_MEM;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_ready <= 1'b0;
      s_rdata <= '0;
    end else begin
      s_ready <= reg_acc;
      s_rdata <= (reg_acc && (s_wstrb == 4'h0)) ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      wsrc_q  <= '0;
      wdst_q  <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ie_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      if (reg_wr && !dma_busy) begin
        case (s_addr)
          REG_SRC: src_q <= apply_strb(src_q, s_wdata, s_wstrb) & ~32'h3;
          REG_DST: dst_q <= apply_strb(dst_q, s_wdata, s_wstrb) & ~32'h3;
          REG_LEN: len_q <= LEN_W'(apply_strb(32'(len_q), s_wdata, s_wstrb));
          default: ;
        endcase
      end
      if (ctrl_wr) begin
        ie_q <= s_wdata[CTRL_IE];
        if (dma_busy) begin
          if (s_wdata[CTRL_ABORT]) abort_q <= 1'b1;
        end else if (s_wdata[CTRL_ABORT]) begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
        end
      end
      // A zero-length start completes on the spot without leaving IDLE.
      if (start_req) begin
        wsrc_q  <= src_q;
        wdst_q  <= dst_q;
        wcnt_q  <= len_q;
        abort_q <= 1'b0;
        err_q   <= 1'b0;
        done_q  <= (len_q == '0);
      end
      case (state)
        ST_RD_MEM: if (mem_done) data_q <= m_rdata;
        ST_RD_ACC: if (acc_done) data_q <= a_rdata;
        ST_NEXT: begin
          wsrc_q <= wsrc_q + 32'(DMA_WORD_BYTES);
          wdst_q <= wdst_q + 32'(DMA_WORD_BYTES);
          wcnt_q <= wcnt_q - LEN_W'(1);
        end
        default: ;
      endcase
      if (state_nxt == ST_DONE) done_q <= 1'b1;
      if (mem_tmo || acc_tmo)   err_q  <= 1'b1;
    end
  end

  dataproc_bus_master #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_mem_master (
    .clk     (clk),
    .resetn  (resetn),
    .req     (mem_req),
    .req_dat (mem_req_dat),
    .valid   (m_valid),
    .addr    (m_addr),
    .wdata   (m_wdata),
    .wstrb   (m_wstrb),
    .ready   (m_ready),
    .done    (mem_done),
    .tmo     (mem_tmo)
  );

  dataproc_bus_master #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_acc_master (
    .clk     (clk),
    .resetn  (resetn),
    .req     (acc_req),
    .req_dat (acc_req_dat),
    .valid   (a_valid),
    .addr    (a_addr),
    .wdata   (a_wdata),
    .wstrb   (a_wstrb),
    .ready   (a_ready),
    .done    (acc_done),
    .tmo     (acc_tmo)
  );

endmodule

// File: tb/tb_dataproc_dma_ctrl.sv
// Bench for dataproc_dma_ctrl: memory and accelerator slave models, scoreboards for memory
// write-backs and register reads, directed scenarios with hand-computed expectations.
module tb_dataproc_dma_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        s_valid, s_ready;
  logic [3:0]  s_addr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        m_valid, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        a_valid, a_ready;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_wstrb;
  logic        irq;

  always #5 clk = ~clk;

  dataproc_dma_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_wstrb(a_wstrb), .a_rdata(a_rdata),
    .irq(irq)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] mem [0:1023];
  int          mem_wait = 0;
  bit          acc_stall = 0;
  bit          acc_rd_stall = 0;
  logic [31:0] acc_din = '0;
  logic [31:0] last_rd_addr = '0;
  int          vld_cycles = 0;
  bit          overlap = 0;
  logic [63:0] exp_wq [$];
  logic [31:0] exp_rq [$];
  string       exp_rn [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory slave: ready after mem_wait cycles of valid; write-backs go to the scoreboard.
  initial begin : mem_slave
    int          cnt;
    bit          bad;
    logic [31:0] la, lw;
    logic [3:0]  ls;
    logic [63:0] e;
    cnt = 0;
    bad = 0;
    forever begin
      @(negedge clk);
      if (m_valid && !m_ready) begin
        if (cnt == 0) begin
          la = m_addr; lw = m_wdata; ls = m_wstrb; bad = 0;
        end else if (m_addr !== la || m_wdata !== lw || m_wstrb !== ls) begin
          bad = 1;
        end
        if (cnt >= mem_wait) begin
          m_ready = 1'b1;
          if (mem_wait > 0) check("mem_stable", 32'(bad), 32'h0);
          if (m_wstrb == 4'h0) begin
            m_rdata      = mem[m_addr[11:2]];
            last_rd_addr = m_addr;
          end else begin
            mem[m_addr[11:2]] = m_wdata;
            check("memwr_strb", 32'(m_wstrb), 32'hF);
            if (exp_wq.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL memwr_unexpected: actual addr=%h expected no write", m_addr);
            end else begin
              e = exp_wq.pop_front();
              check("memwr_addr", m_addr, e[63:32]);
              check("memwr_data", m_wdata, e[31:0]);
            end
          end
        end
        cnt++;
      end else begin
        m_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Accelerator slave: result register returns the last data-in plus one.
  initial begin : acc_slave
    forever begin
      @(negedge clk);
      if (a_valid && !a_ready) begin
        if (!(acc_stall || (acc_rd_stall && a_wstrb == 4'h0))) begin
          a_ready = 1'b1;
          if (a_wstrb != 4'h0) begin
            check("acc_din_addr", a_addr, 32'h0);
            acc_din = a_wdata;
          end else begin
            check("acc_dout_addr", a_addr, 32'h4);
            a_rdata = acc_din + 32'h1;
          end
        end
      end else begin
        a_ready = 1'b0;
      end
    end
  end

  initial begin : vld_mon
    forever begin
      @(negedge clk);
      if (m_valid || a_valid) vld_cycles++;
      if (m_valid && a_valid) overlap = 1;
    end
  end

  initial begin : rd_mon
    forever begin
      @(negedge clk);
      if (s_ready && s_wstrb == 4'h0) begin
        if (exp_rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: actual=%h expected no read", s_rdata);
        end else begin
          check(exp_rn.pop_front(), s_rdata, exp_rq.pop_front());
        end
      end
    end
  end

  task automatic reg_access(input logic [3:0] a, input logic [31:0] d, input logic [3:0] st,
                            output int t_acc);
    int n = 0;
    s_addr = a; s_wdata = d; s_wstrb = st; s_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 20);
    t_acc = cyc;
    check("s_ready_seen", 32'(s_ready), 32'h1);
    s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    int t;
    reg_access(a, d, 4'hF, t);
  endtask

  task automatic reg_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    int t;
    exp_rq.push_back(exp);
    exp_rn.push_back(name);
    reg_access(a, 32'h0, 4'h0, t);
  endtask

  task automatic wait_irq(input int bound, output int t);
    int n = 0;
    while (!irq && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("irq_seen", 32'(irq), 32'h1);
    t = cyc;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int t0, t1, n;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[64] = 32'h1234_5678;
    mem[65] = 32'hDEAD_BEEF;
    mem[66] = 32'hFFFF_FFFF;
    mem[67] = 32'h0000_0041;
    s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    m_ready = 1'b0; m_rdata = '0; a_ready = 1'b0; a_rdata = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    check("rst_irq", 32'(irq), 32'h0);
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_a_valid", 32'(a_valid), 32'h0);
    check("rst_s_ready", 32'(s_ready), 32'h0);
    reg_read(4'hC, 32'h0, "rst_status");

    // Three words, zero-wait slaves; last word wraps 0xFFFFFFFF+1 to 0.
    reg_write(4'h0, 32'h0000_0103);
    reg_read(4'h0, 32'h0000_0100, "src_align");
    reg_write(4'h4, 32'h0000_0200);
    reg_write(4'h8, 32'h3);
    exp_wq.push_back({32'h0000_0200, 32'h1234_5679});
    exp_wq.push_back({32'h0000_0204, 32'hDEAD_BEF0});
    exp_wq.push_back({32'h0000_0208, 32'h0000_0000});
    reg_access(4'hC, 32'h5, 4'hF, t0);
    wait_irq(200, t1);
    check("lat_zero_wait", 32'(t1 - t0), 32'd27);
    reg_read(4'hC, 32'h0000_000A, "status_done");
    reg_write(4'hC, 32'h2);
    reg_read(4'hC, 32'h0, "status_w1c");

    // Zero length: immediate done, no bus activity.
    reg_write(4'h8, 32'h0);
    vld_cycles = 0;
    reg_write(4'hC, 32'h5);
    check("len0_irq", 32'(irq), 32'h1);
    repeat (10) @(negedge clk);
    check("len0_no_bus", 32'(vld_cycles), 32'h0);
    reg_read(4'hC, 32'h0000_000A, "len0_status");
    reg_write(4'hC, 32'h2);

    // Five wait cycles on every memory access: same data, 19 cycles per word.
    mem_wait = 5;
    reg_write(4'h8, 32'h3);
    reg_write(4'h4, 32'h0000_0300);
    exp_wq.push_back({32'h0000_0300, 32'h1234_5679});
    exp_wq.push_back({32'h0000_0304, 32'hDEAD_BEF0});
    exp_wq.push_back({32'h0000_0308, 32'h0000_0000});
    reg_access(4'hC, 32'h5, 4'hF, t0);
    wait_irq(500, t1);
    check("lat_wait5", 32'(t1 - t0), 32'd57);
    reg_write(4'hC, 32'h2);
    mem_wait = 0;

    // Abort during word 2 of 4: word 2 still written back, 2 words remain.
    reg_write(4'h4, 32'h0000_0400);
    reg_write(4'h8, 32'h4);
    exp_wq.push_back({32'h0000_0400, 32'h1234_5679});
    exp_wq.push_back({32'h0000_0404, 32'hDEAD_BEF0});
    last_rd_addr = '0;
    reg_write(4'hC, 32'h1);
    n = 0;
    while (last_rd_addr != 32'h104 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_word2_read", last_rd_addr, 32'h104);
    reg_write(4'hC, 32'h2);
    repeat (40) @(negedge clk);
    reg_read(4'hC, 32'h0002_0000, "abort_status");
    check("abort_wq_empty", 32'(exp_wq.size()), 32'h0);

    // Accelerator never answers: valid withdrawn after 16 cycles, err set.
    acc_stall = 1;
    reg_write(4'h4, 32'h0000_0500);
    reg_write(4'h8, 32'h1);
    reg_access(4'hC, 32'h5, 4'hF, t0);
    n = 0;
    while (!a_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (a_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_valid_cycles", 32'(n), 32'd16);
    acc_stall = 0;
    repeat (2) @(negedge clk);
    check("tmo_irq", 32'(irq), 32'h0);
    reg_read(4'hC, 32'h0001_000C, "tmo_status");
    reg_write(4'hC, 32'h6);
    reg_read(4'hC, 32'h0001_0008, "tmo_w1c");

    // Reset in the middle of the accelerator result read.
    acc_rd_stall = 1;
    reg_write(4'h4, 32'h0000_0600);
    reg_write(4'hC, 32'h5);
    n = 0;
    while (!(a_valid && a_wstrb == 4'h0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_rdacc", 32'(a_valid), 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("arst_a_valid", 32'(a_valid), 32'h0);
    check("arst_m_valid", 32'(m_valid), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    acc_rd_stall = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    reg_read(4'hC, 32'h0, "rst2_status");
    reg_read(4'h0, 32'h0, "rst2_src");
    check("rst2_irq", 32'(irq), 32'h0);

    check("port_overlap", 32'(overlap), 32'h0);
    check("wq_empty", 32'(exp_wq.size()), 32'h0);
    check("rq_empty", 32'(exp_rq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
